// File: rtl/wf_pkg.sv
// Shared word-feeder / DTW definitions: character geometry, FSM states,
// the empty-result substitute byte and the nonzero-prefix length helper.
package wf_pkg;

  localparam int CHAR_W   = 8;
  localparam int CHAR_NUM = 15;
  localparam int WORD_W   = CHAR_W * CHAR_NUM;

  localparam logic [CHAR_W-1:0] EMPTY_CHAR = 8'h3F;

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_SEND    = 3'd3
  } wf_state_e;

  // Number of consecutive nonzero bytes starting at slot 0.
  function automatic logic [3:0] nz_prefix_len(input logic [WORD_W-1:0] w);
    logic [3:0] n;
    logic       run;
    n   = 4'd0;
    run = 1'b1;
    for (int k = 0; k < CHAR_NUM; k++) begin
      if (run && (w[k*CHAR_W +: CHAR_W] != '0)) begin
        n = n + 4'd1;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/word_feeder.sv
// Collects a character stream into a fixed-slot word, hands it to the DTW
// matcher, then streams the best-match word back out byte by byte.
module word_feeder #(
  parameter int CHAR_NUM = 15,
  parameter int CHAR_W   = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic                       i_WF_clk,
  input  logic                       i_WF_rst_n,
  input  logic                       i_WF_char_valid,
  input  logic [CHAR_W-1:0]          i_WF_char,
  input  logic                       i_WF_char_last,
  output logic                       o_WF_char_ready,
  output logic                       o_DTW_start,
  output logic [CHAR_NUM*CHAR_W-1:0] o_DTW_word,
  input  logic                       i_DTW_finish,
  input  logic [CHAR_NUM*CHAR_W-1:0] i_DTW_word,
  output logic                       o_WF_out_valid,
  output logic [CHAR_W-1:0]          o_WF_out_char,
  output logic                       o_WF_out_last,
  input  logic                       i_WF_out_ready,
  output logic                       o_WF_overflow,
  output logic                       o_WF_timeout,
  output logic [2:0]                 o_WF_state
);
  import wf_pkg::*;

  wf_state_e                   r_state;
  logic [CHAR_NUM*CHAR_W-1:0]  r_slots;
  logic [CHAR_NUM*CHAR_W-1:0]  r_result;
  logic [3:0]                  r_count;
  logic [3:0]                  r_idx;
  logic [3:0]                  r_len;
  logic [12:0]                 r_wait_cnt;
  logic                        r_start;
  logic                        r_out_valid;
  logic                        r_out_last;
  logic [CHAR_W-1:0]           r_out_char;
  logic                        r_overflow;
  logic                        r_timeout;

  logic                        w_accept;
  logic                        w_char_nz;
  logic                        w_store;
  logic [3:0]                  w_count_nxt;
  logic [3:0]                  w_res_len;
  logic [3:0]                  w_idx_nxt;

  assign w_accept    = i_WF_char_valid && (r_state == S_COLLECT);
  assign w_char_nz   = (i_WF_char != '0);
  assign w_store     = w_char_nz && (r_count < 4'(CHAR_NUM));
  assign w_count_nxt = w_store ? (r_count + 4'd1) : r_count;
  assign w_res_len   = nz_prefix_len(i_DTW_word);
  assign w_idx_nxt   = r_idx + 4'd1;

  always_ff @(posedge i_WF_clk) begin
    if (!i_WF_rst_n) begin
      r_state     <= S_COLLECT;
      r_slots     <= '0;
      r_result    <= '0;
      r_count     <= 4'd0;
      r_idx       <= 4'd0;
      r_len       <= 4'd0;
      r_wait_cnt  <= 13'd0;
      r_start     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_char  <= '0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            if (w_store) begin
              r_slots[32'(r_count)*CHAR_W +: CHAR_W] <= i_WF_char;
              r_count <= w_count_nxt;
            end else if (w_char_nz) begin
              r_overflow <= 1'b1;
            end
            // A last beat that leaves the word empty is simply absorbed.
            if (i_WF_char_last && (w_count_nxt != 4'd0)) begin
              r_state <= S_START;
            end
          end
        end
        S_START: begin
          r_start    <= 1'b1;
          r_wait_cnt <= 13'd0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (i_DTW_finish) begin
            r_result    <= i_DTW_word;
            r_len       <= w_res_len;
            r_idx       <= 4'd0;
            r_out_valid <= 1'b1;
            r_out_char  <= (w_res_len == 4'd0) ? EMPTY_CHAR : i_DTW_word[CHAR_W-1:0];
            r_out_last  <= (w_res_len <= 4'd1);
            r_state     <= S_SEND;
          end else if (r_wait_cnt == 13'(TIMEOUT-1)) begin
            r_timeout  <= 1'b1;
            r_slots    <= '0;
            r_count    <= 4'd0;
            r_wait_cnt <= 13'd0;
            r_state    <= S_COLLECT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 13'd1;
          end
        end
        S_SEND: begin
          if (r_out_valid && i_WF_out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_slots     <= '0;
              r_count     <= 4'd0;
              r_idx       <= 4'd0;
              r_state     <= S_COLLECT;
            end else begin
              r_idx      <= w_idx_nxt;
              r_out_char <= r_result[32'(w_idx_nxt)*CHAR_W +: CHAR_W];
              r_out_last <= (w_idx_nxt == (r_len - 4'd1));
            end
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign o_WF_char_ready = (r_state == S_COLLECT);
  assign o_DTW_start     = r_start;
  assign o_DTW_word      = r_slots;
  assign o_WF_out_valid  = r_out_valid;
  assign o_WF_out_char   = r_out_char;
  assign o_WF_out_last   = r_out_last;
  assign o_WF_overflow   = r_overflow;
  assign o_WF_timeout    = r_timeout;
  assign o_WF_state      = r_state;

endmodule

// File: tb/tb_word_feeder.sv
// Directed and randomized checks of word_feeder against a queue-based model
// of the collect / DTW handshake / output-stream behaviour.
module tb_word_feeder;

  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_char = 8'h00;
  logic         in_last = 1'b0;
  logic         ready;
  logic         start;
  logic [119:0] dtw_word;
  logic         dtw_finish = 1'b0;
  logic [119:0] dtw_word_in = '0;
  logic         out_valid;
  logic [7:0]   out_char;
  logic         out_last;
  logic         out_ready = 1'b0;
  logic         ovf;
  logic         tmo;
  logic [2:0]   state;

  word_feeder #(.CHAR_NUM(15), .CHAR_W(8), .TIMEOUT(4096)) dut (
    .i_WF_clk(clk), .i_WF_rst_n(rst_n),
    .i_WF_char_valid(in_valid), .i_WF_char(in_char), .i_WF_char_last(in_last),
    .o_WF_char_ready(ready), .o_DTW_start(start), .o_DTW_word(dtw_word),
    .i_DTW_finish(dtw_finish), .i_DTW_word(dtw_word_in),
    .o_WF_out_valid(out_valid), .o_WF_out_char(out_char), .o_WF_out_last(out_last),
    .i_WF_out_ready(out_ready), .o_WF_overflow(ovf), .o_WF_timeout(tmo),
    .o_WF_state(state)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic         model_ovf = 1'b0;
  logic [119:0] exp_word;
  int           exp_cnt;
  logic [7:0]   tx_q[$];
  logic [7:0]   exp_q[$];
  logic [7:0]   rx_q[$];
  logic         rx_last_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [119:0] rand_word(input int nlead);
    logic [119:0] w;
    w = '0;
    for (int k = 0; k < 15; k++) begin
      if (k < nlead)       w[k*8 +: 8] = 8'($urandom_range(1, 255));
      else if (k > nlead)  w[k*8 +: 8] = 8'($urandom_range(0, 255));
    end
    return w;
  endfunction

  task automatic beat(input logic [7:0] c, input logic last);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("beat_ready_wait", {127'b0, ready}, 128'd1);
    in_valid = 1'b1; in_char = c; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_char = 8'h00; in_last = 1'b0;
  endtask

  // Model: nonzero chars fill slots in order up to 15; any further nonzero char sets overflow.
  task automatic send_word(input int idle_max);
    exp_word = '0;
    exp_cnt  = 0;
    foreach (tx_q[i]) begin
      if (tx_q[i] != 8'h00) begin
        if (exp_cnt < 15) begin
          exp_word[exp_cnt*8 +: 8] = tx_q[i];
          exp_cnt++;
        end else begin
          model_ovf = 1'b1;
        end
      end
    end
    foreach (tx_q[i]) begin
      if (idle_max > 0) repeat ($urandom_range(0, idle_max)) @(negedge clk);
      beat(tx_q[i], (i == tx_q.size() - 1));
    end
  endtask

  task automatic check_word(input string tag);
    chk({tag, "_ovf"}, {127'b0, ovf}, {127'b0, model_ovf});
    if (exp_cnt > 0) begin
      chk({tag, "_state_start"}, {125'b0, state}, {125'b0, ST_START});
      chk({tag, "_start_early"}, {127'b0, start}, 128'd0);
      @(negedge clk);
      chk({tag, "_start_pulse"}, {127'b0, start}, 128'd1);
      chk({tag, "_state_wait"}, {125'b0, state}, {125'b0, ST_WAIT});
      chk({tag, "_dtw_word"}, {8'b0, dtw_word}, {8'b0, exp_word});
      @(negedge clk);
      chk({tag, "_start_once"}, {127'b0, start}, 128'd0);
      chk({tag, "_word_stable"}, {8'b0, dtw_word}, {8'b0, exp_word});
    end else begin
      chk({tag, "_stay_collect"}, {125'b0, state}, {125'b0, ST_COLLECT});
      chk({tag, "_no_start"}, {127'b0, start}, 128'd0);
      chk({tag, "_empty_word"}, {8'b0, dtw_word}, 128'd0);
    end
  endtask

  // Model: emitted bytes are the leading nonzero bytes of the result, or a lone '?' if none.
  task automatic do_finish(input string tag, input logic [119:0] w, input int mode);
    logic       got_last;
    logic       hold;
    logic [7:0] hold_char;
    logic       rdy;
    int         n;
    logic       pat[4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_q.delete();
    for (int k = 0; k < 15; k++) begin
      if (w[k*8 +: 8] == 8'h00) break;
      exp_q.push_back(w[k*8 +: 8]);
    end
    if (exp_q.size() == 0) exp_q.push_back(8'h3F);
    dtw_finish = 1'b1; dtw_word_in = w;
    @(negedge clk);
    dtw_finish = 1'b0; dtw_word_in = rand_word(15);
    chk({tag, "_state_send"}, {125'b0, state}, {125'b0, ST_SEND});
    rx_q.delete(); rx_last_q.delete();
    got_last = 1'b0; hold = 1'b0; hold_char = 8'h00; n = 0;
    while (!got_last && n < 200) begin
      if (hold) chk({tag, "_hold_stable"}, {119'b0, out_valid, out_char}, {119'b0, 1'b1, hold_char});
      rdy = (mode == 0) ? ((n < 4) ? pat[n] : 1'b1) : 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (out_valid && rdy) begin
        rx_q.push_back(out_char);
        rx_last_q.push_back(out_last);
        if (out_last) got_last = 1'b1;
      end
      hold = out_valid && !rdy;
      hold_char = out_char;
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    chk({tag, "_got_last"}, {127'b0, got_last}, 128'd1);
    chk({tag, "_back_collect"}, {125'b0, state}, {125'b0, ST_COLLECT});
    chk({tag, "_valid_low"}, {127'b0, out_valid}, 128'd0);
    chk({tag, "_ready_high"}, {127'b0, ready}, 128'd1);
    chk({tag, "_nbytes"}, 128'(rx_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_byte"}, {120'b0, rx_q[i]}, {120'b0, exp_q[i]});
      chk({tag, "_last_flag"}, {127'b0, rx_last_q[i]}, {127'b0, (i == exp_q.size() - 1)});
    end
  endtask

  initial begin
    int n_wait;
    int seen;
    int len;

    repeat (2) @(negedge clk);
    chk("rst_state", {125'b0, state}, {125'b0, ST_COLLECT});
    chk("rst_ready", {127'b0, ready}, 128'd1);
    chk("rst_outs", {122'b0, start, out_valid, out_last, ovf, tmo, 1'b0}, 128'd0);
    chk("rst_out_char", {120'b0, out_char}, 128'd0);
    chk("rst_dtw_word", {8'b0, dtw_word}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    tx_q = {8'h43, 8'h41, 8'h54};
    send_word(0);
    check_word("cat");
    do_finish("cat_out", 120'h544143, 0);

    tx_q = {8'h44, 8'h00, 8'h47};
    send_word(0);
    check_word("zero_skip");
    do_finish("empty_result", 120'h0, 1);

    tx_q = {8'h00};
    send_word(0);
    check_word("only_zero");

    tx_q.delete();
    for (int i = 0; i < 16; i++) tx_q.push_back(8'($urandom_range(1, 255)));
    send_word(1);
    check_word("overflow");
    do_finish("ovf_out", rand_word($urandom_range(0, 15)), 1);

    for (int it = 0; it < 8; it++) begin
      tx_q.delete();
      len = $urandom_range(1, 18);
      for (int i = 0; i < len; i++)
        tx_q.push_back(($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      send_word(2);
      check_word("rand");
      if (exp_cnt > 0) do_finish("rand_out", rand_word($urandom_range(0, 15)), 1);
    end

    tx_q = {8'h51, 8'h52};
    send_word(0);
    check_word("tmo");
    n_wait = 2;
    seen = 0;
    while (seen < 5000) begin
      @(negedge clk);
      seen++;
      if (tmo === 1'b1) break;
      if (state == ST_WAIT) n_wait++;
    end
    chk("tmo_pulse", {127'b0, tmo}, 128'd1);
    chk("tmo_wait_cycles", 128'(n_wait), 128'd4096);
    chk("tmo_state", {125'b0, state}, {125'b0, ST_COLLECT});
    chk("tmo_ready", {127'b0, ready}, 128'd1);
    chk("tmo_cleared", {8'b0, dtw_word}, 128'd0);
    @(negedge clk);
    chk("tmo_one_cycle", {127'b0, tmo}, 128'd0);

    dtw_finish = 1'b1; dtw_word_in = 120'h4F4F;
    @(negedge clk);
    dtw_finish = 1'b0;
    @(negedge clk);
    chk("finish_ignored_state", {125'b0, state}, {125'b0, ST_COLLECT});
    chk("finish_ignored_valid", {127'b0, out_valid}, 128'd0);

    tx_q = {8'h43, 8'h41, 8'h54};
    send_word(0);
    check_word("rst_word");
    dtw_finish = 1'b1; dtw_word_in = 120'h544143;
    @(negedge clk);
    dtw_finish = 1'b0;
    chk("rst_first_byte", {119'b0, out_valid, out_char}, {119'b0, 1'b1, 8'h43});
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_second_byte", {120'b0, out_char}, {120'b0, 8'h41});
    out_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_send_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_send_state", {125'b0, state}, {125'b0, ST_COLLECT});
    chk("rst_send_start", {127'b0, start}, 128'd0);
    chk("rst_send_ovf", {127'b0, ovf}, 128'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid === 1'b1 || start === 1'b1) seen++;
    end
    chk("rst_no_more_bytes", 128'(seen), 128'd0);
    chk("rst_final_state", {125'b0, state}, {125'b0, ST_COLLECT});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
